rv_exec_stage: RTL and testbench
================================

Name: rv_exec_stage

Overview:
- Combined decode / control / execute stage of the three-stage RV32 pipeline (fetch, execute, writeback).
- Accepts the fetched instruction and the register-file read data, and drives the register-file read addresses.
- Computes the ALU result and latches all writeback-stage signals on the next clock edge.
- Drives the writeback port of the register file and the 32-bit hex-display register.

Parameters:
- CSR_IO_IN, 12'hF00, CSR number whose CSRRW copies the switch input io0 into rd.
- CSR_HEX, 12'hF02, CSR number whose CSRRW writes rs1 to the hex register.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr  in  32  instruction in EX stage.
- rs1_data  in  32  register-file read port 1 data (combinational from rs1_addr).
- rs2_data  in  32  register-file read port 2 data.
- io0  in  18  switch input.
- rs1_addr  out  5  instr[19:15].
- rs2_addr  out  5  instr[24:20].
- wb_we  out  1  register-file write enable (WB stage).
- wb_addr  out  5  destination register (WB stage).
- wb_data  out  32  writeback data (WB stage).
- hex_out  out  32  hex display register.

Behaviour:
- Decode fields:
  - opcode=[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25].
  - imm_i=[31:20], sign-extended to 32 bits.
  - imm_u=[31:12].
- OP (0110011), selected by funct7/funct3:
  - funct7=0000000: add/000, sll/001, slt/010, sltu/011, xor/100, srl/101, or/110, and/111.
  - funct7=0100000: sub/000, sra/101.
  - funct7=0000001: mul/000 (low 32 bits), mulh/001 (signed×signed, high 32), mulhu/011 (unsigned×unsigned, high 32).
  - ALU B operand = rs2_data.
- OP-IMM (0010011): addi, slti, sltiu, xori, ori, andi, slli, srli, srai.
  - srai is selected by instr[30]=1.
  - ALU B operand = sign-extended imm_i; shift amount = B[4:0].
- Shifts use B[4:0] only.
- slt/sltu return 32'd1 or 32'd0.
- All arithmetic wraps mod 2^32.
- LUI (0110111): writeback data = {imm_u, 12'h000}.
- SYSTEM (1110011) with funct3=001 (CSRRW):
  - csr=CSR_IO_IN: writeback data = {14'b0, io0}, with io0 sampled in the EX cycle.
  - csr=CSR_HEX: hex_out <= rs1_data at the clock edge; no register write.
- Any other opcode, funct combination, or CSR number executes as a NOP: no register write, no hex write.
- Register write enable is forced to 0 when rd=0.
- Writeback select encoding: 00 = io0, 01 = U-immediate, 10 = ALU result.
- Pipeline register (EX→WB): on the clock edge after the instruction is present, it captures regwe, regsel, rd, ALU result, imm_u and sampled io0.
- Writeback mux is combinational from the pipeline register onto wb_data.
- Latency: an instruction presented in cycle N produces wb_we/wb_addr/wb_data valid during cycle N+1.
- No forwarding and no stall. An instruction reading a register written by the immediately preceding instruction sees the old value; software inserts a NOP.
- Reset (asynchronous) clears:
  - wb_we=0, wb_addr=0, regsel=00, ALU result=0, imm_u=0, io0 register=0.
  - Consequence: wb_data=0 after reset.
  - hex_out=0.
- instr=32'h0 (the value the fetch stage emits during reset) decodes as an illegal opcode and behaves as a NOP.
- Reset asserted mid-operation discards the in-flight writeback.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants (OP, OP_IMM, LUI, SYSTEM);
  - the 4-bit ALU-op enum: AND, OR, XOR, ADD, SUB, MUL, MULH, MULHU, SLL, SRL, SRA, SLT, SLTU;
  - the 2-bit writeback-select enum;
  - the default CSR numbers.
- One natural sub-module, rv_alu: purely combinational, with inputs A, B and op and output R.
- Decode and control logic are combinational always_comb blocks inside rv_exec_stage.

Test Plan:
- Reset with rst=1, then release → wb_we=0, wb_data=0, hex_out=0; instr=0 for 3 cycles keeps wb_we=0.
- addi x1,x0,-5 (32'hFFB00093), rs1_data=0 → next cycle wb_we=1, wb_addr=1, wb_data=32'hFFFFFFFB.
- sub/sra/sltu sweep: rs1_data=32'h80000000, rs2_data=1 → results sub=32'h7FFFFFFF, sra=32'hC0000000, sltu=0, slt=1.
- mulh and mulhu with rs1=rs2=32'hFFFFFFFF → mulh=0, mulhu=32'hFFFFFFFE, mul=1.
- lui x5,0xABCDE → wb_data=32'hABCDE000, wb_addr=5; csrrw x3,0xF00,x0 with io0=18'h3FFFF → wb_data=32'h0003FFFF.
- csrrw x0,0xF02,x7 with rs1_data=32'h12345678 → hex_out=32'h12345678 after edge, wb_we=0; add x0,x1,x2 → wb_we=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the RV32 execute stage: opcodes, ALU operations,
// writeback-select encoding and default CSR numbers.
package rv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [11:0] CSR_IO_IN_DFLT = 12'hF00;
  localparam logic [11:0] CSR_HEX_DFLT   = 12'hF02;

  typedef enum logic [3:0] {
    ALU_AND   = 4'd0,
    ALU_OR    = 4'd1,
    ALU_XOR   = 4'd2,
    ALU_ADD   = 4'd3,
    ALU_SUB   = 4'd4,
    ALU_MUL   = 4'd5,
    ALU_MULH  = 4'd6,
    ALU_MULHU = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_SLT   = 4'd11,
    ALU_SLTU  = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_IO  = 2'b00,
    WB_IMM = 2'b01,
    WB_ALU = 2'b10
  } wb_sel_e;

endpackage

// File: rtl/rv_alu.sv
// Combinational RV32 ALU including the M-extension multiply variants.
module rv_alu
  import rv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] r
);

  logic [63:0] w_prod_ss;
  logic [31:0] w_mulhu;

  // One signed 64-bit product serves all three multiplies; the unsigned high
  // word is recovered by adding back the operands whose sign bit was set.
  assign w_prod_ss = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign w_mulhu   = w_prod_ss[63:32] + (a[31] ? b : 32'd0) + (b[31] ? a : 32'd0);

  always_comb begin
    r = 32'd0;
    case (op)
      ALU_AND:   r = a & b;
      ALU_OR:    r = a | b;
      ALU_XOR:   r = a ^ b;
      ALU_ADD:   r = a + b;
      ALU_SUB:   r = a - b;
      ALU_MUL:   r = w_prod_ss[31:0];
      ALU_MULH:  r = w_prod_ss[63:32];
      ALU_MULHU: r = w_mulhu;
      ALU_SLL:   r = a << b[4:0];
      ALU_SRL:   r = a >> b[4:0];
      ALU_SRA:   r = $signed(a) >>> b[4:0];
      ALU_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
      default:   r = 32'd0;
    endcase
  end

endmodule

// File: rtl/rv_exec_stage.sv
// Decode/control/execute stage of a 3-stage RV32 pipeline with the EX->WB
// pipeline register, writeback mux and hex-display CSR register.
module rv_exec_stage
  import rv_pkg::*;
#(
  parameter logic [11:0] CSR_IO_IN = CSR_IO_IN_DFLT,
  parameter logic [11:0] CSR_HEX   = CSR_HEX_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [17:0] io0,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [31:0] hex_out
);

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [11:0] w_csr;
  logic [31:0] w_imm_i;
  logic [19:0] w_imm_u;

  assign w_opcode = instr[6:0];
  assign w_rd     = instr[11:7];
  assign w_funct3 = instr[14:12];
  assign w_funct7 = instr[31:25];
  assign w_csr    = instr[31:20];
  assign w_imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign w_imm_u  = instr[31:12];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  alu_op_e     w_alu_op;
  wb_sel_e     w_wb_sel;
  logic        w_use_imm;
  logic        w_valid;
  logic        w_hex_we;
  logic        w_regwe;
  logic [31:0] w_alu_b;
  logic [31:0] w_alu_r;

  // Decode: w_valid marks an instruction that writes rd; anything not
  // recognised falls through with all write enables low (a NOP).
  always_comb begin
    w_alu_op  = ALU_ADD;
    w_wb_sel  = WB_ALU;
    w_use_imm = 1'b0;
    w_valid   = 1'b0;
    w_hex_we  = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_valid = 1'b1;
        case ({w_funct7, w_funct3})
          {7'b0000000, 3'b000}: w_alu_op = ALU_ADD;
          {7'b0000000, 3'b001}: w_alu_op = ALU_SLL;
          {7'b0000000, 3'b010}: w_alu_op = ALU_SLT;
          {7'b0000000, 3'b011}: w_alu_op = ALU_SLTU;
          {7'b0000000, 3'b100}: w_alu_op = ALU_XOR;
          {7'b0000000, 3'b101}: w_alu_op = ALU_SRL;
          {7'b0000000, 3'b110}: w_alu_op = ALU_OR;
          {7'b0000000, 3'b111}: w_alu_op = ALU_AND;
          {7'b0100000, 3'b000}: w_alu_op = ALU_SUB;
          {7'b0100000, 3'b101}: w_alu_op = ALU_SRA;
          {7'b0000001, 3'b000}: w_alu_op = ALU_MUL;
          {7'b0000001, 3'b001}: w_alu_op = ALU_MULH;
          {7'b0000001, 3'b011}: w_alu_op = ALU_MULHU;
          default:              w_valid  = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        w_valid   = 1'b1;
        w_use_imm = 1'b1;
        case (w_funct3)
          3'b000:  w_alu_op = ALU_ADD;
          3'b001:  w_alu_op = ALU_SLL;
          3'b010:  w_alu_op = ALU_SLT;
          3'b011:  w_alu_op = ALU_SLTU;
          3'b100:  w_alu_op = ALU_XOR;
          3'b101:  w_alu_op = instr[30] ? ALU_SRA : ALU_SRL;
          3'b110:  w_alu_op = ALU_OR;
          default: w_alu_op = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        w_valid  = 1'b1;
        w_wb_sel = WB_IMM;
      end
      OPC_SYSTEM: begin
        if (w_funct3 == 3'b001) begin
          if (w_csr == CSR_IO_IN) begin
            w_valid  = 1'b1;
            w_wb_sel = WB_IO;
          end else if (w_csr == CSR_HEX) begin
            w_hex_we = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign w_regwe = w_valid && (w_rd != 5'd0);
  assign w_alu_b = w_use_imm ? w_imm_i : rs2_data;

  rv_alu u_alu (
    .a  (rs1_data),
    .b  (w_alu_b),
    .op (w_alu_op),
    .r  (w_alu_r)
  );

  logic        r_wb_we;
  logic [4:0]  r_wb_addr;
  wb_sel_e     r_wb_sel;
  logic [31:0] r_alu;
  logic [19:0] r_imm_u;
  logic [17:0] r_io0;
  logic [31:0] r_hex;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_we   <= 1'b0;
      r_wb_addr <= 5'd0;
      r_wb_sel  <= WB_IO;
      r_alu     <= 32'd0;
      r_imm_u   <= 20'd0;
      r_io0     <= 18'd0;
      r_hex     <= 32'd0;
    end else begin
      r_wb_we   <= w_regwe;
      r_wb_addr <= w_rd;
      r_wb_sel  <= w_wb_sel;
      r_alu     <= w_alu_r;
      r_imm_u   <= w_imm_u;
      r_io0     <= io0;
      if (w_hex_we) r_hex <= rs1_data;
    end
  end

  always_comb begin
    wb_data = 32'd0;
    case (r_wb_sel)
      WB_IO:   wb_data = {14'd0, r_io0};
      WB_IMM:  wb_data = {r_imm_u, 12'h000};
      WB_ALU:  wb_data = r_alu;
      default: wb_data = 32'd0;
    endcase
  end

  assign wb_we   = r_wb_we;
  assign wb_addr = r_wb_addr;
  assign hex_out = r_hex;

endmodule

// File: tb/tb_rv_exec_stage.sv
// Self-checking bench for rv_exec_stage: directed vector table, hand-written
// reset sequences and randomized instructions against a reference model.
module tb_rv_exec_stage;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [17:0] io0;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] hex_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_hex;

  rv_exec_stage dut (
    .clk      (clk),
    .rst      (rst),
    .instr    (instr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .io0      (io0),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .hex_out  (hex_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] csrrw(input logic [11:0] csr, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {csr, rs1, 3'b001, rd, 7'b1110011};
  endfunction

  // Reference model: architectural meaning of each instruction, in plain
  // 64-bit arithmetic.
  function automatic void model(input logic [31:0] ins, input logic [31:0] a,
                                input logic [31:0] b_reg, input logic [17:0] sw,
                                output logic we, output logic [31:0] d,
                                output logic hex_we);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] b;
    logic [63:0] sa, sb, ua, ub, p;
    logic        ok;
    int          sh;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    ok = 1'b0; d = 32'd0; hex_we = 1'b0;
    b  = (opc == 7'h13) ? {{20{ins[31]}}, ins[31:20]} : b_reg;
    sh = int'(b % 32);
    sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
    ua = {32'd0, a};       ub = {32'd0, b};
    if (opc == 7'h33 || opc == 7'h13) begin
      logic alt;
      alt = (opc == 7'h33) ? (f7 == 7'h20) : (f3 == 3'd5 && ins[30]);
      if (opc == 7'h33 && f7 == 7'h01) begin
        ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd3);
        p  = (f3 == 3'd3) ? ua * ub : sa * sb;
        d  = (f3 == 3'd0) ? p[31:0] : p[63:32];
      end else if (opc == 7'h33 && f7 != 7'h00 && f7 != 7'h20) begin
        ok = 1'b0;
      end else begin
        ok = 1'b1;
        case (f3)
          3'd0: d = alt ? a - b : a + b;
          3'd1: d = a << sh;
          3'd2: d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: d = (ua < ub) ? 32'd1 : 32'd0;
          3'd4: d = a ^ b;
          3'd5: begin p = alt ? sa : ua; p = p >> sh; d = p[31:0]; end
          3'd6: d = a | b;
          default: d = a & b;
        endcase
        if (opc == 7'h33 && f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) ok = 1'b0;
      end
    end else if (opc == 7'h37) begin
      ok = 1'b1; d = {ins[31:12], 12'h000};
    end else if (opc == 7'h73 && f3 == 3'd1) begin
      if (ins[31:20] == 12'hF00) begin ok = 1'b1; d = 32'(sw); end
      else if (ins[31:20] == 12'hF02) hex_we = 1'b1;
    end
    we = ok && (ins[11:7] != 5'd0);
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic [17:0] sw);
    @(negedge clk);
    instr = ins; rs1_data = a; rs2_data = b; io0 = sw;
    #1;
    check("rs1_addr", 32'(rs1_addr), 32'(ins[19:15]));
    check("rs2_addr", 32'(rs2_addr), 32'(ins[24:20]));
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [17:0] sw;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] hex;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic        m_we, m_hex;
    logic [31:0] m_d, ins;
    rst = 1'b1; instr = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0; io0 = 18'd0;

    vecs.push_back('{"addi_neg", 32'hFFB00093, 32'd0, 32'd0, 18'd0, 1'b1, 5'd1, 32'hFFFFFFFB, 32'd0});
    vecs.push_back('{"sub", r_type(7'h20, 5'd2, 5'd1, 3'd0, 5'd4), 32'h80000000, 32'd1, 18'd0, 1'b1, 5'd4, 32'h7FFFFFFF, 32'd0});
    vecs.push_back('{"sra", r_type(7'h20, 5'd2, 5'd1, 3'd5, 5'd6), 32'h80000000, 32'd1, 18'd0, 1'b1, 5'd6, 32'hC0000000, 32'd0});
    vecs.push_back('{"sltu", r_type(7'h00, 5'd2, 5'd1, 3'd3, 5'd7), 32'h80000000, 32'd1, 18'd0, 1'b1, 5'd7, 32'd0, 32'd0});
    vecs.push_back('{"slt", r_type(7'h00, 5'd2, 5'd1, 3'd2, 5'd8), 32'h80000000, 32'd1, 18'd0, 1'b1, 5'd8, 32'd1, 32'd0});
    vecs.push_back('{"mul", r_type(7'h01, 5'd2, 5'd1, 3'd0, 5'd9), 32'hFFFFFFFF, 32'hFFFFFFFF, 18'd0, 1'b1, 5'd9, 32'd1, 32'd0});
    vecs.push_back('{"mulh", r_type(7'h01, 5'd2, 5'd1, 3'd1, 5'd10), 32'hFFFFFFFF, 32'hFFFFFFFF, 18'd0, 1'b1, 5'd10, 32'd0, 32'd0});
    vecs.push_back('{"mulhu", r_type(7'h01, 5'd2, 5'd1, 3'd3, 5'd11), 32'hFFFFFFFF, 32'hFFFFFFFF, 18'd0, 1'b1, 5'd11, 32'hFFFFFFFE, 32'd0});
    vecs.push_back('{"lui", 32'hABCDE2B7, 32'd0, 32'd0, 18'd0, 1'b1, 5'd5, 32'hABCDE000, 32'd0});
    vecs.push_back('{"csr_io", csrrw(12'hF00, 5'd0, 5'd3), 32'd0, 32'd0, 18'h3FFFF, 1'b1, 5'd3, 32'h0003FFFF, 32'd0});
    vecs.push_back('{"csr_hex", csrrw(12'hF02, 5'd7, 5'd0), 32'h12345678, 32'd0, 18'd0, 1'b0, 5'd0, 32'd0, 32'h12345678});
    vecs.push_back('{"add_x0", r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 32'd3, 32'd4, 18'd0, 1'b0, 5'd0, 32'd0, 32'h12345678});
    vecs.push_back('{"bad_f7", r_type(7'h20, 5'd2, 5'd1, 3'd1, 5'd12), 32'd3, 32'd4, 18'd0, 1'b0, 5'd0, 32'd0, 32'h12345678});
    vecs.push_back('{"bad_csr", csrrw(12'hF01, 5'd7, 5'd13), 32'hDEAD0000, 32'd0, 18'd5, 1'b0, 5'd0, 32'd0, 32'h12345678});
    vecs.push_back('{"srai", {7'h20, 5'd4, 5'd1, 3'd5, 5'd14, 7'h13}, 32'hF0000000, 32'd0, 18'd0, 1'b1, 5'd14, 32'hFF000000, 32'h12345678});

    // Reset state, held and released, then illegal instr=0 for 3 cycles.
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 32'(wb_we), 32'd0);
    check("rst_data", wb_data, 32'd0);
    check("rst_hex", hex_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'd0, $urandom, $urandom, 18'($urandom));
      check("zero_instr_we", 32'(wb_we), 32'd0);
      check("zero_instr_hex", hex_out, 32'd0);
    end

    // Directed vector table.
    foreach (vecs[i]) begin
      drive(vecs[i].ins, vecs[i].a, vecs[i].b, vecs[i].sw);
      check({vecs[i].name, "_we"}, 32'(wb_we), 32'(vecs[i].we));
      if (vecs[i].we) begin
        check({vecs[i].name, "_addr"}, 32'(wb_addr), 32'(vecs[i].addr));
        check({vecs[i].name, "_data"}, wb_data, vecs[i].data);
      end
      check({vecs[i].name, "_hex"}, hex_out, vecs[i].hex);
    end

    // Randomized instructions against the reference model.
    exp_hex = 32'h12345678;
    for (int i = 0; i < 400; i++) begin
      logic [6:0]  opc;
      logic [6:0]  f7;
      logic [11:0] csr;
      logic [31:0] a, b;
      logic [17:0] sw;
      case ($urandom_range(0, 9))
        0, 1, 2: opc = 7'h33;
        3, 4, 5: opc = 7'h13;
        6:       opc = 7'h37;
        7, 8:    opc = 7'h73;
        default: opc = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      ins = $urandom;
      ins[6:0] = opc;
      if (opc == 7'h33) ins[31:25] = f7;
      if (opc == 7'h13 && ins[14:12] == 3'd5 && $urandom_range(0, 1) == 1)
        ins[31:25] = {1'b0, ins[30], 5'd0};
      if (opc == 7'h73) begin
        case ($urandom_range(0, 2))
          0: csr = 12'hF00;
          1: csr = 12'hF02;
          default: csr = 12'($urandom);
        endcase
        ins[31:20] = csr;
        if ($urandom_range(0, 3) != 0) ins[14:12] = 3'd1;
      end
      if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
      a = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFF : $urandom;
      sw = 18'($urandom);
      model(ins, a, b, sw, m_we, m_d, m_hex);
      if (m_hex) exp_hex = a;
      if (m_we) exp_q.push_back(m_d);
      drive(ins, a, b, sw);
      check("rnd_we", 32'(wb_we), 32'(m_we));
      if (m_we) begin
        check("rnd_addr", 32'(wb_addr), 32'(ins[11:7]));
        check("rnd_data", wb_data, exp_q.pop_front());
      end
      check("rnd_hex", hex_out, exp_hex);
    end

    // Mid-operation reset drops the in-flight writeback and clears hex.
    drive(32'hFFB00093, 32'd0, 32'd0, 18'd0);
    check("pre_rst_we", 32'(wb_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_we", 32'(wb_we), 32'd0);
    check("mid_rst_data", wb_data, 32'd0);
    check("mid_rst_addr", 32'(wb_addr), 32'd0);
    check("mid_rst_hex", hex_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(csrrw(12'hF00, 5'd0, 5'd2), 32'd0, 32'd0, 18'h00ABC);
    check("post_rst_we", 32'(wb_we), 32'd1);
    check("post_rst_data", wb_data, 32'h00000ABC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
